// File: rtl/julia_iter_stage_if.sv
// Pixel stream bundle for julia_iter_stage: read-FIFO side, write-FIFO side and frame constants.
// Signal names follow the stage's documented port list.
interface julia_iter_stage_if #(
  parameter int unsigned ITER_W = 8,
  parameter int unsigned WIDTH  = 32
);
  localparam int unsigned PX_W = ITER_W + 2 * WIDTH;

  logic [PX_W-1:0]  i_Px_Data;
  logic             i_Read_Fifo_Empty;
  logic             i_Write_Fifo_Full;
  logic             i_Mode;
  logic [WIDTH-1:0] i_Cr;
  logic [WIDTH-1:0] i_Ci;
  logic [PX_W-1:0]  o_Px_Data;
  logic             o_Read_Fifo_Ack;
  logic             o_Write_Fifo_Wrreq;
  logic             o_Frame_Done;

  // Environment side: feeds pixels and constants, consumes results.
  modport master (
    output i_Px_Data, i_Read_Fifo_Empty, i_Write_Fifo_Full, i_Mode, i_Cr, i_Ci,
    input  o_Px_Data, o_Read_Fifo_Ack, o_Write_Fifo_Wrreq, o_Frame_Done
  );

  // Iteration stage side.
  modport slave (
    input  i_Px_Data, i_Read_Fifo_Empty, i_Write_Fifo_Full, i_Mode, i_Cr, i_Ci,
    output o_Px_Data, o_Read_Fifo_Ack, o_Write_Fifo_Wrreq, o_Frame_Done
  );
endinterface

// File: rtl/julia_iter_stage.sv
// Two-stage pipelined z <- z^2 + c escape-time iteration in signed fixed point.
// Julia mode (latched i_Mode / i_Cr / i_Ci) is built only when JULIA_MODE_EN is defined.
module julia_iter_stage #(
  parameter int unsigned    WIDTH    = 32,
  parameter int unsigned    FRAC     = 27,
  parameter int unsigned    ITER_W   = 8,
  parameter int unsigned    MAX_ITER = 255,
  parameter int unsigned    H_RES    = 800,
  parameter int unsigned    V_RES    = 480,
  parameter logic [WIDTH-1:0] X_START = WIDTH'(32'hE9560419),
  parameter logic [WIDTH-1:0] Y_START = WIDTH'(32'hF2666666),
  parameter logic [WIDTH-1:0] X_INC   = WIDTH'(32'h0003A051),
  parameter logic [WIDTH-1:0] Y_INC   = WIDTH'(32'h0003A06D)
) (
  input logic             i_Clk,
  input logic             i_Reset,
  julia_iter_stage_if.slave bus
);
  localparam int unsigned PX_W   = ITER_W + 2 * WIDTH;
  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned SUM_W  = WIDTH + 2;
  localparam int unsigned CX_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned CY_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [SUM_W-1:0] FOUR_FX = SUM_W'(1) << (FRAC + 2);

  // Handshake and pixel position
  logic              wr_c, s2_load_c, s1_load_c, ack_c, at_origin_c, last_c;
  logic [CX_W-1:0]   cx_q, cx_d;
  logic [CY_W-1:0]   cy_q, cy_d;
  logic [WIDTH-1:0]  x0_q, x0_d, y0_q, y0_d;

  // Stage 1: pass flag, iteration, z and the truncated products, c
  logic              v1_q, v1_d, pass1_q, pass1_d;
  logic [ITER_W-1:0] iter1_q, iter1_d;
  logic [WIDTH-1:0]  zx1_q, zx1_d, zy1_q, zy1_d;
  logic [WIDTH-1:0]  xx1_q, xx1_d, yy1_q, yy1_d, xy1_q, xy1_d;
  logic [WIDTH-1:0]  cr1_q, cr1_d, ci1_q, ci1_d;

  // Stage 2: finished pixel
  logic              v2_q, v2_d;
  logic [PX_W-1:0]   px2_q, px2_d;

  // Input unpack and stage-1 datapath
  logic [ITER_W-1:0]        in_iter_c;
  logic [WIDTH-1:0]         in_x_c, in_y_c, zx_c, zy_c, cr_sel_c, ci_sel_c;
  logic                     pass_in_c;
  logic signed [PROD_W-1:0] p_xx_c, p_yy_c, p_xy_c;

  // Stage-2 datapath
  logic [SUM_W-1:0]  sum_c;
  logic [WIDTH-1:0]  nx_c, ny_c;
  logic [ITER_W-1:0] iter_inc_c;

`ifdef JULIA_MODE_EN
  logic              mode_q, mode_d, julia_c;
  logic [WIDTH-1:0]  cr_q, cr_d, ci_q, ci_d;
`else
  logic              unused_julia_c;
  assign unused_julia_c = ^{bus.i_Mode, bus.i_Cr, bus.i_Ci};
`endif

  // Pipeline flow control
  always_comb begin
    wr_c        = v2_q & ~bus.i_Write_Fifo_Full;
    s2_load_c   = ~v2_q | wr_c;
    s1_load_c   = ~v1_q | s2_load_c;
    ack_c       = ~bus.i_Read_Fifo_Empty & s1_load_c;
    at_origin_c = (cx_q == '0) && (cy_q == '0);
    last_c      = (cx_q == CX_W'(H_RES - 1)) && (cy_q == CY_W'(V_RES - 1));
  end

  // Raster counters and incremental coordinate accumulators
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    x0_d = x0_q;
    y0_d = y0_q;
    if (ack_c) begin
      if (cx_q == CX_W'(H_RES - 1)) begin
        cx_d = '0;
        x0_d = X_START;
        if (cy_q == CY_W'(V_RES - 1)) begin
          cy_d = '0;
          y0_d = Y_START;
        end else begin
          cy_d = cy_q + CY_W'(1);
          y0_d = y0_q + Y_INC;
        end
      end else begin
        cx_d = cx_q + CX_W'(1);
        x0_d = x0_q + X_INC;
      end
    end
  end

  // c selection; the origin pixel already sees the constants it latches
  always_comb begin
`ifdef JULIA_MODE_EN
    mode_d   = mode_q;
    cr_d     = cr_q;
    ci_d     = ci_q;
    if (ack_c && at_origin_c) begin
      mode_d = bus.i_Mode;
      cr_d   = bus.i_Cr;
      ci_d   = bus.i_Ci;
    end
    julia_c  = at_origin_c ? bus.i_Mode : mode_q;
    cr_sel_c = julia_c ? (at_origin_c ? bus.i_Cr : cr_q) : x0_q;
    ci_sel_c = julia_c ? (at_origin_c ? bus.i_Ci : ci_q) : y0_q;
`else
    cr_sel_c = x0_q;
    ci_sel_c = y0_q;
`endif
  end

  // Stage 1: classify, pick z, square and multiply
  always_comb begin
    in_iter_c = bus.i_Px_Data[PX_W-1 -: ITER_W];
    in_x_c    = bus.i_Px_Data[2*WIDTH-1 -: WIDTH];
    in_y_c    = bus.i_Px_Data[WIDTH-1:0];
    pass_in_c = ((&in_x_c) & (&in_y_c)) | (in_iter_c == ITER_W'(MAX_ITER));
    zx_c      = (pass_in_c || in_iter_c != '0) ? in_x_c : x0_q;
    zy_c      = (pass_in_c || in_iter_c != '0) ? in_y_c : y0_q;
    p_xx_c    = $signed(zx_c) * $signed(zx_c);
    p_yy_c    = $signed(zy_c) * $signed(zy_c);
    p_xy_c    = $signed(zx_c) * $signed(zy_c);

    v1_d    = v1_q;
    pass1_d = pass1_q;
    iter1_d = iter1_q;
    zx1_d   = zx1_q;
    zy1_d   = zy1_q;
    xx1_d   = xx1_q;
    yy1_d   = yy1_q;
    xy1_d   = xy1_q;
    cr1_d   = cr1_q;
    ci1_d   = ci1_q;
    if (s1_load_c) begin
      v1_d = ack_c;
      if (ack_c) begin
        pass1_d = pass_in_c;
        iter1_d = in_iter_c;
        zx1_d   = zx_c;
        zy1_d   = zy_c;
        xx1_d   = WIDTH'(p_xx_c >> FRAC);
        yy1_d   = WIDTH'(p_yy_c >> FRAC);
        xy1_d   = WIDTH'(p_xy_c >> FRAC);
        cr1_d   = cr_sel_c;
        ci1_d   = ci_sel_c;
      end
    end
  end

  // Stage 2: escape test and z^2 + c; squares are non-negative, so they are
  // zero-extended and a square beyond the signed range still counts as large
  always_comb begin
    sum_c      = {2'b00, xx1_q} + {2'b00, yy1_q};
    nx_c       = xx1_q - yy1_q + cr1_q;
    ny_c       = (xy1_q << 1) + ci1_q;
    iter_inc_c = iter1_q + ITER_W'(1);

    v2_d  = v2_q;
    px2_d = px2_q;
    if (s2_load_c) begin
      v2_d = v1_q;
      if (v1_q) begin
        if (pass1_q)
          px2_d = {iter1_q, zx1_q, zy1_q};
        else if (sum_c > FOUR_FX)
          px2_d = {iter1_q, {WIDTH{1'b1}}, {WIDTH{1'b1}}};
        else
          px2_d = {iter_inc_c, nx_c, ny_c};
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cx_q    <= '0;
      cy_q    <= '0;
      x0_q    <= X_START;
      y0_q    <= Y_START;
      v1_q    <= 1'b0;
      pass1_q <= 1'b0;
      iter1_q <= '0;
      zx1_q   <= '0;
      zy1_q   <= '0;
      xx1_q   <= '0;
      yy1_q   <= '0;
      xy1_q   <= '0;
      cr1_q   <= '0;
      ci1_q   <= '0;
      v2_q    <= 1'b0;
      px2_q   <= '0;
    end else begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      v1_q    <= v1_d;
      pass1_q <= pass1_d;
      iter1_q <= iter1_d;
      zx1_q   <= zx1_d;
      zy1_q   <= zy1_d;
      xx1_q   <= xx1_d;
      yy1_q   <= yy1_d;
      xy1_q   <= xy1_d;
      cr1_q   <= cr1_d;
      ci1_q   <= ci1_d;
      v2_q    <= v2_d;
      px2_q   <= px2_d;
    end
  end

`ifdef JULIA_MODE_EN
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      mode_q <= 1'b0;
      cr_q   <= '0;
      ci_q   <= '0;
    end else begin
      mode_q <= mode_d;
      cr_q   <= cr_d;
      ci_q   <= ci_d;
    end
  end
`endif

  // Outputs are forced quiet for the whole time reset is held
  assign bus.o_Read_Fifo_Ack    = ack_c & ~i_Reset;
  assign bus.o_Write_Fifo_Wrreq = wr_c & ~i_Reset;
  assign bus.o_Frame_Done       = ack_c & last_c & ~i_Reset;
  assign bus.o_Px_Data          = i_Reset ? '0 : px2_q;

endmodule

// File: tb/tb_julia_iter_stage.sv
// Directed bench for julia_iter_stage: reset, iteration vectors, pass-through,
// backpressure, frame wrap and (with JULIA_MODE_EN) Julia constant latching.
module tb_julia_iter_stage;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ITER_W = 8;
  localparam int unsigned PX_W   = ITER_W + 2 * WIDTH;
  localparam logic [31:0] ONES   = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  julia_iter_stage_if #(.ITER_W(ITER_W), .WIDTH(WIDTH)) bus ();

  // Position-sensitive vectors run right after a reset so they land on (0,0);
  // non-zero increments let the frame-wrap test see the accumulators move.
  julia_iter_stage #(
    .WIDTH(32), .FRAC(27), .ITER_W(8), .MAX_ITER(255), .H_RES(4), .V_RES(2),
    .X_START(32'h08000000), .Y_START(32'h00000000),
    .X_INC(32'h01000000), .Y_INC(32'h04000000)
  ) dut (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [PX_W-1:0] pxw(input logic [7:0] it, input logic [31:0] x,
                                          input logic [31:0] y);
    return {it, x, y};
  endfunction

  task automatic chk(input string tag, input logic [PX_W-1:0] obs, input logic [PX_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    bus.i_Read_Fifo_Empty = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // One pixel through an empty pipe: Ack now, nothing next cycle, result two cycles on.
  task automatic send_one(input string tag, input logic [PX_W-1:0] din, input logic [PX_W-1:0] dexp);
    @(negedge clk);
    bus.i_Px_Data         = din;
    bus.i_Read_Fifo_Empty = 1'b0;
    bus.i_Write_Fifo_Full = 1'b0;
    #1 chk({tag, "_ack"}, PX_W'(bus.o_Read_Fifo_Ack), PX_W'(1));
    @(negedge clk);
    bus.i_Read_Fifo_Empty = 1'b1;
    #1 chk({tag, "_wr_early"}, PX_W'(bus.o_Write_Fifo_Wrreq), PX_W'(0));
    @(negedge clk);
    #1 chk({tag, "_wr"}, PX_W'(bus.o_Write_Fifo_Wrreq), PX_W'(1));
    chk({tag, "_data"}, bus.o_Px_Data, dexp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, PX_W'(bus.o_Read_Fifo_Ack), PX_W'(0));
    chk({tag, "_wr"}, PX_W'(bus.o_Write_Fifo_Wrreq), PX_W'(0));
    chk({tag, "_done"}, PX_W'(bus.o_Frame_Done), PX_W'(0));
    chk({tag, "_data"}, bus.o_Px_Data, PX_W'(0));
  endtask

  function automatic logic [PX_W-1:0] bp_px(input int k);
    return {8'd255, 32'hA0000000 + 32'(k), 32'h00000100 * 32'(k)};
  endfunction

  logic [31:0] fw_x [9];
  logic [31:0] fw_y [9];

  initial begin
    int sent;
    int got;
    fw_x = '{32'h10000000, 32'h13200000, 32'h16800000, 32'h1A200000,
             32'h0E000000, 32'h11200000, 32'h14800000, 32'h18200000, 32'h10000000};
    fw_y = '{32'h0, 32'h0, 32'h0, 32'h0,
             32'h0C000000, 32'h0D000000, 32'h0E000000, 32'h0F000000, 32'h0};

    rst                   = 1'b1;
    bus.i_Px_Data         = '0;
    bus.i_Read_Fifo_Empty = 1'b1;
    bus.i_Write_Fifo_Full = 1'b0;
    bus.i_Mode            = 1'b0;
    bus.i_Cr              = '0;
    bus.i_Ci              = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill both stages behind a full write FIFO, then reset for three cycles.
    @(negedge clk);
    bus.i_Px_Data         = pxw(8'd0, 32'h0, 32'h0);
    bus.i_Read_Fifo_Empty = 1'b0;
    bus.i_Write_Fifo_Full = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.i_Write_Fifo_Full = 1'b0;
    #1 chk_quiet("rst_c0");
    @(negedge clk); #1 chk_quiet("rst_c1");
    @(negedge clk); #1 chk_quiet("rst_c2");
    @(negedge clk);
    rst = 1'b0;
    bus.i_Read_Fifo_Empty = 1'b1;
    #1 chk_quiet("post_rst");
    @(negedge clk); #1 chk("flush_a", PX_W'(bus.o_Write_Fifo_Wrreq), PX_W'(0));
    @(negedge clk); #1 chk("flush_b", PX_W'(bus.o_Write_Fifo_Wrreq), PX_W'(0));

    // Mandelbrot sequence at pixel (0,0), c = (1.0, 0)
    send_one("mand1", pxw(8'd0, 32'h0, 32'h0), pxw(8'd1, 32'h10000000, 32'h0));
    do_reset(2);
    send_one("mand2", pxw(8'd1, 32'h10000000, 32'h0), pxw(8'd2, 32'h28000000, 32'h0));
    do_reset(2);
    send_one("mand3", pxw(8'd2, 32'h28000000, 32'h0), pxw(8'd2, ONES, ONES));

    // Pass-through: escaped and capped
    send_one("escaped", pxw(8'd7, ONES, ONES), pxw(8'd7, ONES, ONES));
    send_one("capped", pxw(8'd255, 32'h01000000, 32'h0), pxw(8'd255, 32'h01000000, 32'h0));
    send_one("capped_iter0", pxw(8'd0, ONES, ONES), pxw(8'd0, ONES, ONES));

    // Backpressure: full held for cycles 3..7 while both stages hold pixels
    do_reset(2);
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      bus.i_Read_Fifo_Empty = (sent >= 10);
      bus.i_Px_Data         = bp_px(sent);
      bus.i_Write_Fifo_Full = (c >= 3 && c < 8);
      #1;
      if (c >= 3 && c < 8) begin
        chk("bp_stall_ack", PX_W'(bus.o_Read_Fifo_Ack), PX_W'(0));
        chk("bp_stall_wr", PX_W'(bus.o_Write_Fifo_Wrreq), PX_W'(0));
        chk("bp_stall_data", bus.o_Px_Data, bp_px(1));
      end
      if (bus.o_Read_Fifo_Ack === 1'b1) sent++;
      if (bus.o_Write_Fifo_Wrreq === 1'b1) begin
        chk("bp_order", bus.o_Px_Data, bp_px(got));
        got++;
      end
    end
    chk("bp_sent", PX_W'(sent), PX_W'(10));
    chk("bp_got", PX_W'(got), PX_W'(10));
    bus.i_Write_Fifo_Full = 1'b0;
    @(negedge clk); #1 chk("bp_no_dup", PX_W'(bus.o_Write_Fifo_Wrreq), PX_W'(0));

    // Frame wrap over a 4x2 frame plus one pixel of the next frame
    do_reset(2);
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 9; c++) begin
      @(negedge clk);
      bus.i_Read_Fifo_Empty = (sent >= 9);
      bus.i_Px_Data         = pxw(8'd0, 32'h0, 32'h0);
      #1;
      if (bus.o_Read_Fifo_Ack === 1'b1) begin
        chk("fw_done", PX_W'(bus.o_Frame_Done), PX_W'(sent == 7));
        sent++;
      end
      if (bus.o_Write_Fifo_Wrreq === 1'b1) begin
        chk("fw_data", bus.o_Px_Data, pxw(8'd1, fw_x[got], fw_y[got]));
        got++;
      end
    end
    chk("fw_got", PX_W'(got), PX_W'(9));
    bus.i_Read_Fifo_Empty = 1'b1;

`ifdef JULIA_MODE_EN
    // Julia constants latch at (0,0); mid-frame changes wait for the next frame
    do_reset(2);
    bus.i_Mode = 1'b1;
    bus.i_Cr   = 32'h0;
    bus.i_Ci   = 32'h0;
    send_one("julia_origin", pxw(8'd0, 32'h0, 32'h0), pxw(8'd1, 32'h08000000, 32'h0));
    bus.i_Mode = 1'b0;
    bus.i_Cr   = 32'h08000000;
    send_one("julia_hold", pxw(8'd0, 32'h0, 32'h0), pxw(8'd1, 32'h0A200000, 32'h0));
    for (int k = 0; k < 6; k++)
      send_one("julia_fill", pxw(8'd255, 32'h0, 32'h0), pxw(8'd255, 32'h0, 32'h0));
    send_one("julia_next", pxw(8'd0, 32'h0, 32'h0), pxw(8'd1, 32'h10000000, 32'h0));
`else
    // Without Julia support the mode and constant inputs have no effect
    do_reset(2);
    bus.i_Mode = 1'b1;
    bus.i_Cr   = 32'h12345678;
    bus.i_Ci   = 32'h0ABCDEF0;
    send_one("mode_ignored", pxw(8'd0, 32'h0, 32'h0), pxw(8'd1, 32'h10000000, 32'h0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/julia_iter_stage.md
# julia_iter_stage

Parametrised, two-stage pipelined escape-time iteration stage for the LCD fractal renderer. Sits between the pixel read FIFO and write FIFO. Each accepted pixel advances one iteration of z ← z² + c in signed fixed point, in Mandelbrot or Julia mode. Successor to the single-cycle combinational iteration stage, adding:
- configurable width, precision and resolution;
- registered backpressure handling;
- an iteration cap;
- a selectable Julia constant.

## Interface
Parameters:
- WIDTH, 32, bits per coordinate (signed two's complement)
- FRAC, 27, fractional bits (Q(WIDTH-FRAC).FRAC)
- ITER_W, 8, iteration counter width
- MAX_ITER, 255, iteration cap
- H_RES, 800, pixels per line
- V_RES, 480, lines per frame
- X_START, 32'hE9560419, real coordinate of pixel (0,0)
- Y_START, 32'hF2666666, imaginary coordinate of pixel (0,0)
- X_INC, 32'h0003A051, real step per pixel
- Y_INC, 32'h0003A06D, imaginary step per line

Ports:
- i_Clk  in  1  clock; all logic on its rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Px_Data  in  ITER_W+2*WIDTH  {iteration, X, Y} from the read FIFO (show-ahead)
- i_Read_Fifo_Empty  in  1  read FIFO empty
- i_Write_Fifo_Full  in  1  write FIFO full
- i_Mode  in  1  0 = Mandelbrot, 1 = Julia
- i_Cr, i_Ci  in  WIDTH each  Julia constant c
- o_Px_Data  out  ITER_W+2*WIDTH  {iteration, X, Y} to the write FIFO
- o_Read_Fifo_Ack  out  1  consume the current read FIFO word
- o_Write_Fifo_Wrreq  out  1  write o_Px_Data
- o_Frame_Done  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
**Pixel position**
- Counters cx (0..H_RES-1) and cy (0..V_RES-1) advance on each accept; cx wraps to 0 and increments cy, and cy wraps to 0.
- Coordinates are held in accumulators:
  - x0 = X_START + cx·X_INC
  - y0 = Y_START + cy·Y_INC
- The accumulators are updated incrementally (add the INC; reload the START on wrap). No multipliers are used for coordinates.

**Frame constants**
- i_Mode, i_Cr and i_Ci are latched when the pixel at (0,0) is accepted. They stay fixed for the rest of the frame.
- At reset: mode 0, c = 0.

**Per-pixel rule (priority order)**
1. Escaped: input X and Y both all-ones → pass through unchanged.
2. Capped: iteration == MAX_ITER → pass through unchanged.
3. Initialise: if iteration == 0, z = (x0, y0); otherwise z = (X, Y).
4. Select c:
   - Mandelbrot: c = (x0, y0)
   - Julia: c = (Cr, Ci)
5. Products are full 2·WIDTH signed and truncated to bits [FRAC+WIDTH-1:FRAC].
6. Escape test: if x² + y² > 4.0, output X = Y = all-ones with the iteration unchanged. The sum is evaluated in WIDTH+2 bits so it cannot wrap.
7. Otherwise:
   - X' = x² − y² + cr
   - Y' = 2xy + ci
   - iteration + 1
   - Both X' and Y' wrap modulo 2^WIDTH.

## Timing
**Pipeline**
- Stage 1 registers z, c and the truncated products; stage 2 registers the result.
- Valid bits are v1 and v2.
- o_Write_Fifo_Wrreq = v2 & ~i_Write_Fifo_Full.
- Stage 2 loads when ~v2 or a write occurs.
- Stage 1 loads when ~v1 or stage 2 loads.
- o_Read_Fifo_Ack = ~i_Read_Fifo_Empty & (stage 1 loads).

**Throughput and latency**
- Throughput: 1 pixel per cycle.
- Latency: accepted at cycle N → Wrreq with the result at cycle N+2, if not stalled.
- On stall, o_Px_Data and both stages hold. No pixel is lost, duplicated or reordered.

**Timing of related signals**
- o_Frame_Done is asserted in the same cycle as the Ack of pixel (H_RES-1, V_RES-1).
- Simultaneous empty and full: Ack and Wrreq are both 0, and everything holds.

**Reset**
- Reset at any time, including mid-frame or mid-stall:
  - clears v1, v2, cx, cy and the latched mode/c;
  - reloads the accumulators to X_START / Y_START;
  - discards pixels in flight.
- Outputs during and after reset: o_Read_Fifo_Ack = 0, o_Write_Fifo_Wrreq = 0, o_Frame_Done = 0, o_Px_Data = 0.

## Configuration
- JULIA_MODE_EN defined: Julia mode operates as described.
- JULIA_MODE_EN undefined:
  - i_Mode, i_Cr and i_Ci are ignored;
  - the latched mode is tied to 0;
  - c is always (x0, y0);
  - no Julia-constant registers are built.
- Ports are identical in both builds.

## Test plan
Unless stated otherwise, tests use X_START = 32'h08000000 (1.0), Y_START = 0 and X_INC = Y_INC = 0.
- **Reset:** hold i_Reset 3 cycles with the FIFO non-empty → Ack, Wrreq, Frame_Done and o_Px_Data all 0; the first post-reset accept uses x0 = X_START.
- **Mandelbrot sequence:**
  - input {0, 0, 0} → {1, 32'h10000000, 0};
  - feed back {1, 32'h10000000, 0} → {2, 32'h28000000, 0};
  - feed back again → {2, FFFFFFFF, FFFFFFFF}.
- **Pass-through:**
  - {7, FFFFFFFF, FFFFFFFF} → unchanged;
  - {255, 32'h01000000, 0} → unchanged (cap).
- **Backpressure:** stream 10 pixels and hold full high 5 cycles with both stages valid → Ack and Wrreq low, o_Px_Data stable; after release, all 10 pixels are written in order, exactly once.
- **Frame wrap:** with H_RES = 4 and V_RES = 2, make 8 accepts → Frame_Done pulses on the 8th Ack only; the 9th pixel uses x0 = X_START, y0 = Y_START.
- **Julia latch:** with JULIA_MODE_EN defined, set i_Mode = 1 and i_Cr = i_Ci = 0 before pixel (0,0) → {0, 0, 0} → {1, 32'h08000000, 0}. Toggle i_Mode mid-frame → no effect until the next (0,0) accept. With the macro undefined → Mandelbrot result {1, 32'h10000000, 0}.
